// File: rtl/div4bit_restoring.sv
// div4bit_restoring: sequential restoring unsigned divider, one quotient bit per clock, start/done handshake.
module div4bit_restoring #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_n;
    logic [N:0]    r, r_n, t, diff;
    logic [N-1:0]  q, q_n, d, d_n, quotient_n, remainder_n;
    logic [CW-1:0] count, count_n;
    logic          dbz_n;

    // Trial subtraction: a clear MSB of diff means the shifted remainder covers the divisor.
    assign t    = {r[N-1:0], q[N-1]};
    assign diff = t - {1'b0, d};
    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            r           <= r_n;
            q           <= q_n;
            d           <= d_n;
            count       <= count_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            div_by_zero <= dbz_n;
        end
    end

    always_comb begin
        state_n     = state;
        r_n         = r;
        q_n         = q;
        d_n         = d;
        count_n     = count;
        quotient_n  = quotient;
        remainder_n = remainder;
        dbz_n       = div_by_zero;
        case (state)
            IDLE: if (start) begin
                d_n = divisor;
                q_n = dividend;
                r_n = '0;
                if (divisor == '0) begin
                    state_n     = DONE;
                    quotient_n  = '1;
                    remainder_n = dividend;
                    dbz_n       = 1'b1;
                end else begin
                    state_n = CALC;
                    count_n = CW'(N);
                end
            end
            CALC: begin
                r_n     = diff[N] ? t : diff;
                q_n     = {q[N-2:0], ~diff[N]};
                count_n = count - CW'(1);
                if (count == CW'(1)) begin
                    state_n     = DONE;
                    quotient_n  = q_n;
                    remainder_n = r_n[N-1:0];
                    dbz_n       = 1'b0;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_div4bit_restoring.sv
// tb_div4bit_restoring: randomized and directed self-checking bench for the restoring divider.
module tb_div4bit_restoring;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dividend = '0, divisor = '0;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder;
    int         n_checks = 0;
    int         n_fail = 0;

    div4bit_restoring #(.N(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic int exp_q(input int a, input int b);
        return (b == 0) ? 15 : a / b;
    endfunction

    function automatic int exp_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    // Drives one start pulse; returns at the first negedge after the capture edge.
    task automatic launch(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {busy, done, div_by_zero, quotient, remainder});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        int cyc, nb;
        launch(4'd13, 4'd3);
        nb = busy ? 1 : 0;
        cyc = 1;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (busy) nb++;
        end
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d want 5", cyc); end
        n_checks++; if (nb !== 5) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 5", nb); end
        n_checks++; if (quotient !== 4'd4) begin n_fail++; $display("FAIL basic_q: got %0d want 4", quotient); end
        n_checks++; if (remainder !== 4'd1) begin n_fail++; $display("FAIL basic_r: got %0d want 1", remainder); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_pulse_end: done/busy got %b want 00", {done, busy}); end
        n_checks++;
        if ({quotient, remainder} !== {4'd4, 4'd1}) begin n_fail++; $display("FAIL basic_hold: got %0d/%0d want 4/1", quotient, remainder); end
    endtask

    task automatic test_back_to_back;
        int as [3] = '{15, 15, 5};
        int bs [3] = '{1, 15, 7};
        int cyc, idle;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dividend = 4'(as[i]); divisor = 4'(bs[i]);
            cyc = 0; idle = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (!busy) idle++;
            end while (!done && cyc < 30);
            n_checks++;
            if (cyc !== (i == 0 ? 5 : 6)) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, cyc, i == 0 ? 5 : 6); end
            n_checks++;
            if (idle !== (i == 0 ? 0 : 1)) begin n_fail++; $display("FAIL b2b_idle[%0d]: got %0d want %0d", i, idle, i == 0 ? 0 : 1); end
            n_checks++;
            if (quotient !== 4'(exp_q(as[i], bs[i])) || remainder !== 4'(exp_r(as[i], bs[i])))  begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got %0d/%0d want %0d/%0d", i, quotient, remainder, exp_q(as[i], bs[i]), exp_r(as[i], bs[i]));
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div_by_zero;
        int cyc;
        launch(4'd9, 4'd0);
        wait_done(cyc);
        n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL dbz_latency: got %0d want 1", cyc); end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {4'd15, 4'd9, 1'b1}) begin
            n_fail++; $display("FAIL dbz_result: got %0d/%0d/%b want 15/9/1", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_hold: got %b want 1", div_by_zero); end
        launch(4'd8, 4'd2);
        wait_done(cyc);
        n_checks++;
        if ({cyc[3:0], quotient, remainder, div_by_zero} !== {4'd5, 4'd4, 4'd0, 1'b0}) begin
            n_fail++; $display("FAIL dbz_followup: got cyc %0d %0d/%0d/%b want cyc 5 4/0/0", cyc, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_busy_ignore;
        int nd = 0;
        logic [3:0] gq = '0, gr = '0;
        launch(4'd12, 4'd5);
        dividend = 4'd7; divisor = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (done) begin nd++; gq = quotient; gr = remainder; end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin nd++; gq = quotient; gr = remainder; end
        end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
        n_checks++;
        if ({gq, gr} !== {4'd2, 4'd2}) begin n_fail++; $display("FAIL ignore_result: got %0d/%0d want 2/2", gq, gr); end
    endtask

    task automatic test_reset_mid;
        int nd = 0, cyc;
        launch(4'd14, 4'd3);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 11'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got %b want 0", {busy, done, div_by_zero, quotient, remainder});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL midreset_activity: got %0d want 0", nd); end
        launch(4'd6, 4'd4);
        wait_done(cyc);
        n_checks++;
        if ({cyc[3:0], quotient, remainder} !== {4'd5, 4'd1, 4'd2}) begin
            n_fail++; $display("FAIL midreset_followup: got cyc %0d %0d/%0d want cyc 5 1/2", cyc, quotient, remainder);
        end
    endtask

    task automatic test_exhaustive;
        int cyc, bad = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                launch(4'(a), 4'(b));
                wait_done(cyc);
                n_checks++;
                if (b == 0) begin
                    if (cyc !== 1 || quotient !== 4'd15 || remainder !== 4'(a) || div_by_zero !== 1'b1) begin
                        n_fail++; bad++;
                        if (bad < 10) $display("FAIL exh_dbz %0d/0: got cyc %0d %0d/%0d/%b want cyc 1 15/%0d/1", a, cyc, quotient, remainder, div_by_zero, a);
                    end
                end else if (cyc !== 5 || div_by_zero !== 1'b0 || int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b) begin
                    n_fail++; bad++;
                    if (bad < 10) $display("FAIL exh_inv %0d/%0d: got cyc %0d %0d/%0d/%b want cyc 5 %0d/%0d/0", a, b, cyc, quotient, remainder, div_by_zero, a / b, a % b);
                end
            end
        end
    endtask

    task automatic test_random;
        int a, b, cyc, bad = 0;
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch(4'(a), 4'(b));
            dividend = 4'($urandom); divisor = 4'($urandom);
            wait_done(cyc);
            n_checks++;
            if (cyc !== (b == 0 ? 1 : 5) || quotient !== 4'(exp_q(a, b)) || remainder !== 4'(exp_r(a, b)) || div_by_zero !== (b == 0)) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rand %0d/%0d: got cyc %0d %0d/%0d/%b want %0d/%0d", a, b, cyc, quotient, remainder, div_by_zero, exp_q(a, b), exp_r(a, b));
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_div_by_zero;
        test_busy_ignore;
        test_reset_mid;
        test_exhaustive;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
